safety_axi_mem_responder: RTL



---
 rtl/safety_island_pkg.sv | 101 ++++++++++
 rtl/safety_axi_mem_burst_ctr.sv | 48 ++++
 rtl/safety_axi_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/safety_island_pkg.sv
// Shared types and helpers for the safety-island AXI memory responder:
// channel structs, FSM states, response merging and beat-address sequencing.
package safety_island_pkg;

  localparam int unsigned SiaAddrWidth = 32;
  localparam int unsigned SiaDataWidth = 64;
  localparam int unsigned SiaIdWidth   = 2;
  localparam int unsigned SiaUserWidth = 10;
  localparam int unsigned SiaStrbWidth = SiaDataWidth / 8;
  localparam int unsigned MaxAddrWidth = 64;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;

  typedef struct packed {
    logic [SiaIdWidth-1:0]   id;
    logic [SiaAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [5:0]              atop;
    logic [SiaUserWidth-1:0] user;
  } sia_aw_chan_t;

  typedef struct packed {
    logic [SiaDataWidth-1:0] data;
    logic [SiaStrbWidth-1:0] strb;
    logic                    last;
    logic [SiaUserWidth-1:0] user;
  } sia_w_chan_t;

  typedef struct packed {
    logic [SiaIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [SiaUserWidth-1:0] user;
  } sia_b_chan_t;

  typedef struct packed {
    logic [SiaIdWidth-1:0]   id;
    logic [SiaAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [SiaUserWidth-1:0] user;
  } sia_ar_chan_t;

  typedef struct packed {
    logic [SiaIdWidth-1:0]   id;
    logic [SiaDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [SiaUserWidth-1:0] user;
  } sia_r_chan_t;

  typedef struct packed {
    sia_aw_chan_t aw;
    logic         aw_valid;
    sia_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    sia_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } sia_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    sia_b_chan_t b;
    logic        r_valid;
    sia_r_chan_t r;
  } sia_axi_resp_t;

  // Worst-of ordering is DECERR > SLVERR > OKAY; EXOKAY never occurs here.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // INCR realigns to the transfer size so an unaligned first beat is corrected.
  function automatic logic [MaxAddrWidth-1:0] beat_addr_next(input logic [2:0] size,
                                                             input logic [1:0] burst,
                                                             input logic [MaxAddrWidth-1:0] addr);
    logic [MaxAddrWidth-1:0] step;
    step = MaxAddrWidth'(1) << size;
    if (burst == BURST_INCR) return (addr & ~(step - MaxAddrWidth'(1))) + step;
    return addr;
  endfunction

endpackage

// File: rtl/safety_axi_mem_burst_ctr.sv
// Beat counter and address generator for one AXI burst; one instance per
// direction of the memory responder.
module safety_axi_mem_burst_ctr
  import safety_island_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start,
  input  logic [AddrWidth-1:0] addr,
  input  logic [7:0]           len,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  input  logic                 advance,
  output logic [AddrWidth-1:0] beat_addr,
  output logic                 last
);

  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [7:0]           cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      addr_q  <= addr;
      len_q   <= len;
      size_q  <= size;
      burst_q <= burst;
      cnt_q   <= '0;
    end else if (advance) begin
      addr_q <= AddrWidth'(beat_addr_next(size_q, burst_q, MaxAddrWidth'(addr_q)));
      cnt_q  <= cnt_q + 8'd1;
    end
  end

  assign beat_addr = addr_q;
  assign last      = (cnt_q == len_q);

endmodule

// File: rtl/safety_axi_mem_responder.sv
// AXI4 subordinate backed by a register-array memory, with independent
// single-outstanding read and write engines.
module safety_axi_mem_responder
  import safety_island_pkg::*;
#(
  parameter int unsigned             AxiAddrWidth = 32,
  parameter int unsigned             AxiDataWidth = 64,
  parameter int unsigned             AxiIdWidth   = 2,
  parameter int unsigned             AxiUserWidth = 10,
  parameter int unsigned             NumWords     = 1024,
  parameter logic [AxiAddrWidth-1:0] BaseAddr     = 32'h1000_0000,
  parameter type                     axi_req_t    = sia_axi_req_t,
  parameter type                     axi_resp_t   = sia_axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int unsigned StrbW   = AxiDataWidth / 8;
  localparam int unsigned SizeMax = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(NumWords);
  localparam logic [AxiAddrWidth-1:0] MemBytes = AxiAddrWidth'(NumWords * StrbW);

  function automatic logic in_range(input logic [AxiAddrWidth-1:0] a);
    return (a - BaseAddr) < MemBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [AxiAddrWidth-1:0] a);
    return IdxW'((a - BaseAddr) >> SizeMax);
  endfunction

  function automatic logic burst_illegal(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(SizeMax)) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

  logic [AxiDataWidth-1:0] mem [NumWords];

  w_state_e                w_state_q, w_state_d;
  logic [AxiIdWidth-1:0]   w_id_q;
  logic                    w_illegal_q;
  logic [1:0]              w_err_q, w_err_d;
  logic [1:0]              w_beat_resp;
  logic                    w_start, w_advance, w_last, mem_we;
  logic [AxiAddrWidth-1:0] w_beat_addr;
  logic                    aw_ready, w_ready, b_valid;

  r_state_e                r_state_q, r_state_d;
  logic [AxiIdWidth-1:0]   r_id_q;
  logic                    r_illegal_q;
  logic                    r_start, r_advance, r_last;
  logic [AxiAddrWidth-1:0] r_beat_addr;
  logic                    ar_ready, r_valid, r_last_o;
  logic [1:0]              r_resp;
  logic [AxiDataWidth-1:0] r_data;

  logic unused_fields;
  assign unused_fields = ^{axi_req_i.aw.atop, axi_req_i.aw.user,
                           axi_req_i.w.user, axi_req_i.ar.user};

  safety_axi_mem_burst_ctr #(.AddrWidth(AxiAddrWidth)) i_w_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (w_start),
    .addr      (axi_req_i.aw.addr),
    .len       (axi_req_i.aw.len),
    .size      (axi_req_i.aw.size),
    .burst     (axi_req_i.aw.burst),
    .advance   (w_advance),
    .beat_addr (w_beat_addr),
    .last      (w_last)
  );

  safety_axi_mem_burst_ctr #(.AddrWidth(AxiAddrWidth)) i_r_ctr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start     (r_start),
    .addr      (axi_req_i.ar.addr),
    .len       (axi_req_i.ar.len),
    .size      (axi_req_i.ar.size),
    .burst     (axi_req_i.ar.burst),
    .advance   (r_advance),
    .beat_addr (r_beat_addr),
    .last      (r_last)
  );

  // Write engine: the burst always ends on the beat counter, never on w.last.
  always_comb begin
    w_state_d   = w_state_q;
    w_err_d     = w_err_q;
    w_beat_resp = RESP_OKAY;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    mem_we      = 1'b0;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi_req_i.aw_valid) begin
          w_start   = 1'b1;
          w_err_d   = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          w_advance = 1'b1;
          if (w_illegal_q) begin
            w_beat_resp = RESP_SLVERR;
          end else if (!in_range(w_beat_addr)) begin
            w_beat_resp = RESP_DECERR;
          end else begin
            mem_we = 1'b1;
          end
          if (axi_req_i.w.last != w_last) begin
            w_beat_resp = resp_merge(w_beat_resp, RESP_SLVERR);
          end
          w_err_d = resp_merge(w_err_q, w_beat_resp);
          if (w_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q   <= W_IDLE;
      w_err_q     <= RESP_OKAY;
      w_id_q      <= '0;
      w_illegal_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_err_q   <= w_err_d;
      if (w_start) begin
        w_id_q      <= axi_req_i.aw.id;
        w_illegal_q <= burst_illegal(axi_req_i.aw.size, axi_req_i.aw.burst);
      end
    end
  end

  // Contents survive reset, so this array deliberately has no reset branch.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (axi_req_i.w.strb[b]) mem[word_idx(w_beat_addr)][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
      end
    end
  end

  // Read engine: data comes straight from the array, so a same-cycle write is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    r_start   = 1'b0;
    r_advance = 1'b0;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_resp    = RESP_OKAY;
    r_data    = '0;
    r_last_o  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (axi_req_i.ar_valid) begin
          r_start   = 1'b1;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        r_valid  = 1'b1;
        r_last_o = r_last;
        if (r_illegal_q) begin
          r_resp = RESP_SLVERR;
        end else if (!in_range(r_beat_addr)) begin
          r_resp = RESP_DECERR;
        end else begin
          r_data = mem[word_idx(r_beat_addr)];
        end
        if (axi_req_i.r_ready) begin
          r_advance = 1'b1;
          if (r_last) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q   <= R_IDLE;
      r_id_q      <= '0;
      r_illegal_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (r_start) begin
        r_id_q      <= axi_req_i.ar.id;
        r_illegal_q <= burst_illegal(axi_req_i.ar.size, axi_req_i.ar.burst);
      end
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b.id     = b_valid ? w_id_q : '0;
    axi_resp_o.b.resp   = b_valid ? w_err_q : RESP_OKAY;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r.id     = r_valid ? r_id_q : '0;
    axi_resp_o.r.data   = r_data;
    axi_resp_o.r.resp   = r_resp;
    axi_resp_o.r.last   = r_last_o;
  end

endmodule
